// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler
// Latches hall and cabin calls into a pending mask, chooses the next floor
// with a SCAN (collective) policy, steps the car one floor per travel period
// and holds the door open for a fixed time at every served floor.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   hall_req, cab_req  per-floor call inputs (level or pulse, merged)
//   car_floor_o        current car floor
//   dir_up_o           current travel / preference direction (1 = up)
//   moving_o           car travelling between floors
//   door_open_o        door phase at the current floor
//   busy_o             not idle or calls outstanding
//   pending_o          registered pending-request mask
module lift_call_scheduler #(
  parameter int FLOORS        = 8,
  parameter int FW            = 3,
  parameter int HOME_FLOOR    = 0,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLOORS-1:0] hall_req,
  input  logic [FLOORS-1:0] cab_req,
  output logic [FW-1:0]     car_floor_o,
  output logic              dir_up_o,
  output logic              moving_o,
  output logic              door_open_o,
  output logic              busy_o,
  output logic [FLOORS-1:0] pending_o
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic              dir_up_q, dir_up_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [TW-1:0]     travel_q, travel_d;
  logic [DW-1:0]     door_q, door_d;

  logic [FW-1:0]     cur_floor_s;
  logic [FW-1:0]     next_floor_s;
  logic [FLOORS-1:0] cur_onehot_s;
  logic [FLOORS-1:0] next_onehot_s;
  logic [FLOORS-1:0] served_s;
  logic              above_s, below_s, here_s, arrive_hit_s;

  // Floor decode: stray floor codes fold to HOME_FLOOR; derive ahead/behind flags.
  always_comb begin
    if (int'(floor_q) < FLOORS) begin
      cur_floor_s = floor_q;
    end else begin
      cur_floor_s = FW'(HOME_FLOOR);
    end
    if (dir_up_q) begin
      next_floor_s = cur_floor_s + FW'(1);
    end else begin
      next_floor_s = cur_floor_s - FW'(1);
    end
    above_s       = 1'b0;
    below_s       = 1'b0;
    cur_onehot_s  = '0;
    next_onehot_s = '0;
    for (int i = 0; i < FLOORS; i++) begin
      cur_onehot_s[i]  = (i == int'(cur_floor_s));
      next_onehot_s[i] = (i == int'(next_floor_s));
      if (pending_q[i] && (i > int'(cur_floor_s))) begin
        above_s = 1'b1;
      end else if (pending_q[i] && (i < int'(cur_floor_s))) begin
        below_s = 1'b1;
      end else begin
        above_s = above_s;
      end
    end
    here_s       = |(pending_q & cur_onehot_s);
    arrive_hit_s = |(pending_q & next_onehot_s);
  end

  // Next-state logic for the car sequencer and the pending mask.
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_up_d = dir_up_q;
    travel_d = travel_q;
    door_d   = door_q;
    served_s = '0;
    case (state_q)
      ST_IDLE: begin
        if (here_s) begin
          state_d  = ST_DOOR;
          door_d   = '0;
          served_s = cur_onehot_s;
        end else if (dir_up_q && above_s) begin
          state_d  = ST_MOVE;
          travel_d = '0;
        end else if (!dir_up_q && below_s) begin
          state_d  = ST_MOVE;
          travel_d = '0;
        end else if (above_s || below_s) begin
          // Nothing ahead: flip preference and re-decide next cycle.
          dir_up_d = ~dir_up_q;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MOVE: begin
        if (travel_q == TW'(TRAVEL_CYCLES - 1)) begin
          travel_d = '0;
          floor_d  = next_floor_s;
          if (arrive_hit_s) begin
            state_d  = ST_DOOR;
            door_d   = '0;
            served_s = next_onehot_s;
          end else begin
            state_d = ST_MOVE;
          end
        end else begin
          travel_d = travel_q + TW'(1);
        end
      end
      ST_DOOR: begin
        // Calls for this floor while the door is open are absorbed.
        served_s = cur_onehot_s;
        if (door_q == DW'(DOOR_CYCLES - 1)) begin
          state_d = ST_IDLE;
          door_d  = '0;
        end else begin
          door_d = door_q + DW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pending_d = (pending_q | hall_req | cab_req) & ~served_s;
  end

  // State, position, direction, counters and pending register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      floor_q   <= FW'(HOME_FLOOR);
      dir_up_q  <= 1'b1;
      pending_q <= '0;
      travel_q  <= '0;
      door_q    <= '0;
    end else begin
      state_q   <= state_d;
      floor_q   <= floor_d;
      dir_up_q  <= dir_up_d;
      pending_q <= pending_d;
      travel_q  <= travel_d;
      door_q    <= door_d;
    end
  end

  assign car_floor_o = floor_q;
  assign dir_up_o    = dir_up_q;
  assign moving_o    = (state_q == ST_MOVE);
  assign door_open_o = (state_q == ST_DOOR);
  assign busy_o      = (state_q != ST_IDLE) || (pending_q != '0);
  assign pending_o   = pending_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Directed self-checking bench for lift_call_scheduler (default parameters).
// Inputs change just after the falling edge; outputs are checked there too.
module tb_lift_call_scheduler;

  logic       clk;
  logic       rst_n;
  logic [7:0] hall_req;
  logic [7:0] cab_req;
  logic [2:0] car_floor_o;
  logic       dir_up_o;
  logic       moving_o;
  logic       door_open_o;
  logic       busy_o;
  logic [7:0] pending_o;

  int checks;
  int errors;

  lift_call_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hall_req    (hall_req),
    .cab_req     (cab_req),
    .car_floor_o (car_floor_o),
    .dir_up_o    (dir_up_o),
    .moving_o    (moving_o),
    .door_open_o (door_open_o),
    .busy_o      (busy_o),
    .pending_o   (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] fl, input logic dir,
                         input logic mv, input logic dr, input logic bz,
                         input logic [7:0] pend);
    chk({tag, ".floor"},   32'(car_floor_o), 32'(fl));
    chk({tag, ".dir"},     32'(dir_up_o),    32'(dir));
    chk({tag, ".moving"},  32'(moving_o),    32'(mv));
    chk({tag, ".door"},    32'(door_open_o), 32'(dr));
    chk({tag, ".busy"},    32'(busy_o),      32'(bz));
    chk({tag, ".pending"}, 32'(pending_o),   32'(pend));
  endtask

  // Watchdog: the directed sequence is a few hundred cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    hall_req = 8'h00;
    cab_req  = 8'h00;

    // Reset
    tick();
    tick();
    chk_all("reset", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (3) tick();
    chk_all("idle_hold", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Same-floor call at floor 0
    hall_req = 8'h01;
    tick();
    hall_req = 8'h00;
    chk_all("same.latched", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("same.door", 3'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    end
    tick();
    chk_all("same.done", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Up trip 0 -> 5
    cab_req = 8'h20;
    tick();
    cab_req = 8'h00;
    chk_all("up.latched", 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h20);
    tick();
    chk_all("up.start", 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20);
    for (int f = 1; f <= 5; f++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("up.travel_floor", 32'(car_floor_o), 32'(f - 1));
        chk("up.travel_moving", 32'(moving_o), 32'd1);
      end
      tick();
      chk("up.step_floor", 32'(car_floor_o), 32'(f));
    end
    chk_all("up.arrive", 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    repeat (2) tick();
    chk_all("up.door_last", 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    chk_all("up.idle", 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // SCAN order from floor 5 going up: 6, 7, reverse, 2
    cab_req  = 8'h80;
    hall_req = 8'h44;
    tick();
    cab_req  = 8'h00;
    hall_req = 8'h00;
    chk_all("scan.latched", 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC4);
    tick();
    chk_all("scan.start", 3'd5, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC4);
    repeat (4) tick();
    chk_all("scan.stop6", 3'd6, 1'b1, 1'b0, 1'b1, 1'b1, 8'h84);
    repeat (3) tick();
    chk_all("scan.idle6", 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 8'h84);
    tick();
    chk_all("scan.move7", 3'd6, 1'b1, 1'b1, 1'b0, 1'b1, 8'h84);
    repeat (4) tick();
    chk_all("scan.stop7", 3'd7, 1'b1, 1'b0, 1'b1, 1'b1, 8'h04);
    repeat (3) tick();
    chk_all("scan.idle7", 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'h04);
    tick();
    chk_all("scan.reverse", 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 8'h04);
    tick();
    chk_all("scan.move_down", 3'd7, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04);
    repeat (19) tick();
    chk_all("scan.before2", 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h04);
    tick();
    chk_all("scan.stop2", 3'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    repeat (3) tick();
    chk_all("scan.idle2", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Absorb during door at floor 3 (needs a reversal first)
    cab_req = 8'h08;
    tick();
    cab_req = 8'h00;
    tick();
    chk_all("absorb.reverse", 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'h08);
    tick();
    chk_all("absorb.move", 3'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h08);
    repeat (4) tick();
    chk_all("absorb.arrive", 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    hall_req = 8'h08;
    tick();
    hall_req = 8'h00;
    chk_all("absorb.door2", 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    chk_all("absorb.door3", 3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
    tick();
    chk_all("absorb.closed", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) tick();
    chk_all("absorb.no_restop", 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Reset mid-move: trip 3 -> 6 aborted between floors
    cab_req = 8'h40;
    tick();
    cab_req = 8'h00;
    tick();
    repeat (6) tick();
    chk_all("rstmv.moving", 3'd4, 1'b1, 1'b1, 1'b0, 1'b1, 8'h40);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rstmv.abort", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk_all("rstmv.idle", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
